// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM pipeline stage: control bundle, FSM states, memory widths.
package Defs;

  localparam int DMEM_ADDR_W = 8;
  localparam int DATA_W      = 8;
  localparam int REG_IDX_W   = 3;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic imm_to_reg;
  } ControlSignals;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

  // Write-back value for instructions that do not wait on memory.
  function automatic logic [DATA_W-1:0] wb_select(input ControlSignals ctrl,
                                                  input logic [DATA_W-1:0] imm_val,
                                                  input logic [DATA_W-1:0] alu_result);
    return ctrl.imm_to_reg ? imm_val : alu_result;
  endfunction

endpackage

// File: rtl/mem_access_stage_timeout_ctr.sv
// Counts REQ cycles spent waiting on dmem_ready; tc flags the last permitted cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory loads/stores over req/ready, stalls upstream while
// an access is pending, and registers the MEM/WB write-back values plus sticky errors.
module mem_access_stage
  import Defs::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  ControlSignals          control_in,
  input  logic [DATA_W-1:0]      alu_result_in,
  input  logic [DATA_W-1:0]      rd_val_in,
  input  logic [REG_IDX_W-1:0]   rd_in,
  input  logic [DATA_W-1:0]      imm_val_in,
  input  logic                   exp_error_in,
  output logic                   stall_out,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  input  logic                   dmem_ready,
  input  logic [DATA_W-1:0]      dmem_rdata,
  output logic                   wb_reg_write,
  output logic [REG_IDX_W-1:0]   wb_rd,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   err_exp,
  output logic                   err_timeout
);

  mem_state_e           state, state_next;
  logic                 errored, start, tc, done;
  logic                 lat_reg_write, lat_mem_to_reg;
  logic [REG_IDX_W-1:0] lat_rd;

  mem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .enable ((state == REQ) && !dmem_ready),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    errored    = exp_error_in | (control_in.mem_read & control_in.mem_write);
    start      = 1'b0;
    done       = dmem_ready | tc;
    case (state)
      IDLE: begin
        start = (control_in.mem_read | control_in.mem_write) & !errored;
        if (start) begin
          stall_out  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall_out = !done;
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Outputs are all quiet while reset is held, even with a mem op waiting upstream.
    if (reset) stall_out = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      lat_reg_write  <= 1'b0;
      lat_mem_to_reg <= 1'b0;
      lat_rd         <= '0;
      wb_reg_write   <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      err_exp        <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      wb_reg_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dmem_req       <= 1'b1;
            dmem_we        <= control_in.mem_write;
            dmem_addr      <= alu_result_in;
            dmem_wdata     <= rd_val_in;
            lat_reg_write  <= control_in.reg_write;
            lat_mem_to_reg <= control_in.mem_to_reg;
            lat_rd         <= rd_in;
          end else begin
            wb_reg_write <= control_in.reg_write & !errored;
            wb_rd        <= rd_in;
            wb_data      <= wb_select(control_in, imm_val_in, alu_result_in);
            if (errored) err_exp <= 1'b1;
          end
        end
        REQ: begin
          // Ready wins over a coincident timeout.
          if (dmem_ready) begin
            dmem_req     <= 1'b0;
            wb_reg_write <= lat_reg_write;
            wb_rd        <= lat_rd;
            wb_data      <= lat_mem_to_reg ? dmem_rdata : dmem_addr;
          end else if (tc) begin
            dmem_req    <= 1'b0;
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected write-backs are queued at issue
// and popped when the stage presents them.
module tb_mem_access_stage;
  import Defs::*;

  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  ControlSignals control_in;
  logic [7:0]    alu_result_in, rd_val_in, imm_val_in, dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic [2:0]    rd_in, wb_rd;
  logic          exp_error_in, stall_out, dmem_req, dmem_we, dmem_ready;
  logic          wb_reg_write, err_exp, err_timeout;

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .control_in(control_in), .alu_result_in(alu_result_in),
    .rd_val_in(rd_val_in), .rd_in(rd_in), .imm_val_in(imm_val_in), .exp_error_in(exp_error_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_exp(err_exp), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] c, input logic [7:0] alu, input logic [7:0] rdv,
                       input logic [2:0] rd, input logic [7:0] imm, input logic exc);
    control_in    = ControlSignals'(c);
    alu_result_in = alu;
    rd_val_in     = rdv;
    rd_in         = rd;
    imm_val_in    = imm;
    exp_error_in  = exc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'b11010, 8'h44, 8'h00, 3'd1, 8'h00, 1'b0);
    dmem_ready = 1'b0;
    dmem_rdata = 8'h00;
    @(negedge clk);
    checks++;
    if ({stall_out, dmem_req, dmem_we, wb_reg_write, err_exp, err_timeout} !== 6'b0 ||
        dmem_addr !== 8'h00 || dmem_wdata !== 8'h00 || wb_rd !== 3'd0 || wb_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b req=%b we=%b wbw=%b eexp=%b eto=%b addr=%h wdata=%h rd=%0d data=%h, want all 0",
               stall_out, dmem_req, dmem_we, wb_reg_write, err_exp, err_timeout, dmem_addr, dmem_wdata, wb_rd, wb_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(5'b00000, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic test_alu();
    wb_t e;
    @(posedge clk); #1;
    drive(5'b10000, 8'h5A, 8'h00, 3'd3, 8'h11, 1'b0);
    exp_q.push_back('{rd: 3'd3, data: 8'h5A});
    @(negedge clk);
    checks++;
    if (stall_out !== 1'b0) begin
      errors++; $display("FAIL alu_stall: got %b want 0", stall_out);
    end
    @(posedge clk); #1;
    drive(5'b00000, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wb_reg_write !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data) begin
      errors++; $display("FAIL alu_wb: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h", wb_reg_write, wb_rd, wb_data, e.rd, e.data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (wb_reg_write !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL bubble: got we=%b stall=%b want 0 0", wb_reg_write, stall_out);
    end
  endtask

  // Random ALU/immediate ops back to back; stray dmem_ready in IDLE must be ignored.
  task automatic test_back_to_back();
    wb_t        e;
    logic [7:0] a, im;
    logic [2:0] r;
    logic       use_imm;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i < 6) begin
        a       = 8'($urandom_range(0, 255));
        im      = 8'($urandom_range(0, 255));
        r       = 3'($urandom_range(0, 7));
        use_imm = 1'($urandom_range(0, 1));
        drive(use_imm ? 5'b10001 : 5'b10000, a, 8'hEE, r, im, 1'b0);
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = 8'($urandom_range(0, 255));
        exp_q.push_back('{rd: r, data: use_imm ? im : a});
      end else begin
        drive(5'b00000, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
        dmem_ready = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (stall_out !== 1'b0 || dmem_req !== 1'b0) begin
        errors++; $display("FAIL b2b_nostall[%0d]: got stall=%b req=%b want 0 0", i, stall_out, dmem_req);
      end
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (wb_reg_write !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data) begin
          errors++; $display("FAIL b2b_wb[%0d]: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h", i, wb_reg_write, wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  endtask

  task automatic test_load();
    wb_t e;
    int  stalls = 0;
    @(posedge clk); #1;
    drive(5'b11010, 8'h10, 8'h00, 3'd2, 8'h99, 1'b0);
    exp_q.push_back('{rd: 3'd2, data: 8'hC3});
    @(negedge clk);
    if (stall_out) stalls++;
    @(posedge clk); #1;
    dmem_ready = 1'b1;
    dmem_rdata = 8'hC3;
    @(negedge clk);
    if (stall_out) stalls++;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 8'h10) begin
      errors++; $display("FAIL load_req: got req=%b we=%b addr=%h want 1 0 10", dmem_req, dmem_we, dmem_addr);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    drive(5'b00000, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (dmem_req !== 1'b0 || wb_reg_write !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data) begin
      errors++; $display("FAIL load_wb: got req=%b we=%b rd=%0d data=%h want req=0 we=1 rd=%0d data=%h", dmem_req, wb_reg_write, wb_rd, wb_data, e.rd, e.data);
    end
    checks++;
    if (stalls != 1) begin
      errors++; $display("FAIL load_stalls: got %0d want 1", stalls);
    end
  endtask

  task automatic test_store();
    int stalls = 0;
    @(posedge clk); #1;
    drive(5'b00100, 8'hFF, 8'h77, 3'd6, 8'h00, 1'b0);
    @(negedge clk);
    if (stall_out) stalls++;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      dmem_ready = (k == 3);
      drive(5'b00000, 8'h01, 8'h02, 3'd0, 8'h00, 1'b0); // must not disturb latched values
      control_in = ControlSignals'(5'b00100);
      @(negedge clk);
      if (stall_out) stalls++;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'hFF || dmem_wdata !== 8'h77) begin
        errors++; $display("FAIL store_req[%0d]: got req=%b we=%b addr=%h wdata=%h want 1 1 ff 77", k, dmem_req, dmem_we, dmem_addr, dmem_wdata);
      end
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    drive(5'b00000, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || wb_reg_write !== 1'b0 || stalls != 3 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL store_done: got req=%b we=%b stalls=%0d eto=%b want 0 0 3 0", dmem_req, wb_reg_write, stalls, err_timeout);
    end
  endtask

  // Ready arrives in the very cycle the timeout would fire: completes normally.
  task automatic test_ready_at_timeout();
    wb_t e;
    @(posedge clk); #1;
    drive(5'b11010, 8'h33, 8'h00, 3'd5, 8'h00, 1'b0);
    exp_q.push_back('{rd: 3'd5, data: 8'hA7});
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      dmem_ready = (k == TO);
      dmem_rdata = 8'hA7;
    end
    @(negedge clk);
    checks++;
    if (stall_out !== 1'b0 || dmem_req !== 1'b1) begin
      errors++; $display("FAIL rat_last: got stall=%b req=%b want 0 1", stall_out, dmem_req);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    drive(5'b00000, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (err_timeout !== 1'b0 || wb_reg_write !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data) begin
      errors++; $display("FAIL rat_wb: got eto=%b we=%b rd=%0d data=%h want eto=0 we=1 rd=%0d data=%h", err_timeout, wb_reg_write, wb_rd, wb_data, e.rd, e.data);
    end
  endtask

  task automatic test_timeout();
    wb_t  e;
    int   req_cycles = 0;
    logic fin = 1'b0;
    @(posedge clk); #1;
    drive(5'b11010, 8'h20, 8'h00, 3'd4, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (stall_out !== 1'b1) begin
      errors++; $display("FAIL to_stall0: got %b want 1", stall_out);
    end
    for (int c = 0; c < 12 && !fin; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (dmem_req) req_cycles++;
      if (!stall_out) fin = 1'b1;
    end
    checks++;
    if (!fin) begin
      errors++; $display("FAIL to_bound: stall still %b after 12 cycles, want 0", stall_out);
    end
    @(posedge clk); #1;
    drive(5'b10000, 8'h3C, 8'h00, 3'd1, 8'h00, 1'b0);
    exp_q.push_back('{rd: 3'd1, data: 8'h3C});
    @(negedge clk);
    checks++;
    if (req_cycles != TO || dmem_req !== 1'b0 || err_timeout !== 1'b1 || wb_reg_write !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL to_done: got reqcyc=%0d req=%b eto=%b we=%b stall=%b want %0d 0 1 0 0", req_cycles, dmem_req, err_timeout, wb_reg_write, stall_out, TO);
    end
    @(posedge clk); #1;
    drive(5'b00000, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wb_reg_write !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data || err_timeout !== 1'b1) begin
      errors++; $display("FAIL to_next: got we=%b rd=%0d data=%h eto=%b want we=1 rd=%0d data=%h eto=1", wb_reg_write, wb_rd, wb_data, err_timeout, e.rd, e.data);
    end
  endtask

  task automatic test_errors();
    logic [4:0] ctl [2] = '{5'b10100, 5'b11100};
    logic       exc [2] = '{1'b1, 1'b0};
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      checks++;
      if (err_exp !== 1'b0 || err_timeout !== 1'b0) begin
        errors++; $display("FAIL err_clear[%0d]: got eexp=%b eto=%b want 0 0", t, err_exp, err_timeout);
      end
      @(posedge clk); #1;
      drive(ctl[t], 8'h40, 8'h55, 3'd7, 8'h00, exc[t]);
      @(negedge clk);
      checks++;
      if (stall_out !== 1'b0) begin
        errors++; $display("FAIL err_stall[%0d]: got %b want 0", t, stall_out);
      end
      @(posedge clk); #1;
      drive(5'b00000, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || wb_reg_write !== 1'b0 || err_exp !== 1'b1) begin
          errors++; $display("FAIL err_resp[%0d.%0d]: got req=%b we=%b eexp=%b want 0 0 1", t, k, dmem_req, wb_reg_write, err_exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_access();
    wb_t e;
    @(posedge clk); #1;
    drive(5'b11010, 8'h66, 8'h00, 3'd2, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin
      errors++; $display("FAIL rma_pre: got req=%b stall=%b want 1 1", dmem_req, stall_out);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || wb_reg_write !== 1'b0 || wb_data !== 8'h00 || wb_rd !== 3'd0) begin
      errors++; $display("FAIL rma_drop: got req=%b stall=%b we=%b rd=%0d data=%h want all 0", dmem_req, stall_out, wb_reg_write, wb_rd, wb_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(5'b10000, 8'hB4, 8'h00, 3'd6, 8'h00, 1'b0);
    exp_q.push_back('{rd: 3'd6, data: 8'hB4});
    @(negedge clk);
    checks++;
    if (stall_out !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL rma_alu_stall: got stall=%b req=%b want 0 0", stall_out, dmem_req);
    end
    @(posedge clk); #1;
    drive(5'b00000, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wb_reg_write !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data) begin
      errors++; $display("FAIL rma_alu_wb: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h", wb_reg_write, wb_rd, wb_data, e.rd, e.data);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_store();
    test_ready_at_timeout();
    test_timeout();
    test_errors();
    test_reset_mid_access();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
